// File: rtl/ppg_multichannel_calibrator_pkg.sv
// Shared state encoding and small arithmetic helpers for the PPG calibrator.
package ppg_multichannel_calibrator_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE       = 3'd0;
   localparam state_t ST_CAL_SETTLE = 3'd1;
   localparam state_t ST_CAL_ADJUST = 3'd2;
   localparam state_t ST_CAL_DONE   = 3'd3;
   localparam state_t ST_RUN_SETTLE = 3'd4;

   // Index width that never collapses to zero, so a single channel still has a port bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int unsigned sat_inc(input int unsigned v, input int unsigned mx);
      return (v >= mx) ? mx : v + 1;
   endfunction

   function automatic int unsigned sat_dec(input int unsigned v);
      return (v == 0) ? 0 : v - 1;
   endfunction

endpackage

// File: rtl/ppg_multichannel_calibrator_cal_step.sv
// One calibration decision: given the latched ADC value and current codes,
// produce the adjusted codes and whether the channel locks or fails.
module ppg_cal_step
   import ppg_multichannel_calibrator_pkg::*;
#(
   parameter int ADC_W     = 8,
   parameter int DRIVE_W   = 4,
   parameter int DCC_W     = 7,
   parameter int GAIN_W    = 4,
   parameter int ITER_W    = 7,
   parameter int TARGET_LO = 64,
   parameter int TARGET_HI = 192,
   parameter int MAX_ITER  = 64
) (
   input  logic [ADC_W-1:0]   v,
   input  logic [DRIVE_W-1:0] drive,
   input  logic [DCC_W-1:0]   dcc,
   input  logic [GAIN_W-1:0]  gain,
   input  logic [ITER_W-1:0]  iter,
   output logic [DRIVE_W-1:0] next_drive,
   output logic [DCC_W-1:0]   next_dcc,
   output logic [GAIN_W-1:0]  next_gain,
   output logic [ITER_W-1:0]  next_iter,
   output logic               lock,
   output logic               fail
);

   localparam logic [DRIVE_W-1:0] DRIVE_MAX = '1;
   localparam logic [DCC_W-1:0]   DCC_MAX   = '1;
   localparam logic [GAIN_W-1:0]  GAIN_MAX  = '1;

   logic sat;

   always_comb begin
      next_drive = drive;
      next_dcc   = dcc;
      next_gain  = gain;
      sat        = 1'b0;
      lock       = (v >= ADC_W'(TARGET_LO)) && (v <= ADC_W'(TARGET_HI));
      // Too bright: pull DC compensation first, then back off the LED.
      if (v > ADC_W'(TARGET_HI)) begin
         if (dcc != DCC_MAX)    next_dcc   = DCC_W'(sat_inc(32'(dcc), 32'(DCC_MAX)));
         else if (drive != '0)  next_drive = DRIVE_W'(sat_dec(32'(drive)));
         else                   sat        = 1'b1;
      end else if (v < ADC_W'(TARGET_LO)) begin
         if (gain != GAIN_MAX)       next_gain  = GAIN_W'(sat_inc(32'(gain), 32'(GAIN_MAX)));
         else if (drive != DRIVE_MAX) next_drive = DRIVE_W'(sat_inc(32'(drive), 32'(DRIVE_MAX)));
         else                        sat        = 1'b1;
      end
      next_iter = ITER_W'(sat_inc(32'(iter), MAX_ITER));
      fail      = !lock && (sat || (next_iter >= ITER_W'(MAX_ITER)));
   end

endmodule

// File: rtl/ppg_multichannel_calibrator.sv
// Multi-channel PPG LED calibrator: per-channel search for drive/DC-comp/gain,
// then round-robin sampling of the good channels with their stored settings.
module ppg_multichannel_calibrator
   import ppg_multichannel_calibrator_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int ADC_W      = 8,
   parameter int DRIVE_W    = 4,
   parameter int DCC_W      = 7,
   parameter int GAIN_W     = 4,
   parameter int DRIVE_INIT = 8,
   parameter int SETTLE_CYC = 4,
   parameter int TARGET_LO  = 64,
   parameter int TARGET_HI  = 192,
   parameter int MAX_ITER   = 64,
   localparam int CH_W      = clog2_min1(NUM_CH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               find_setting,
   input  logic               run_en,
   input  logic [ADC_W-1:0]   adc,
   output logic [NUM_CH-1:0]  led_en,
   output logic [DRIVE_W-1:0] led_drive,
   output logic [DCC_W-1:0]   dc_comp,
   output logic [GAIN_W-1:0]  pga_gain,
   output logic               busy,
   output logic               cal_done,
   output logic [NUM_CH-1:0]  cal_fail,
   output logic               sample_valid,
   output logic [CH_W-1:0]    sample_ch,
   output logic [ADC_W-1:0]   sample_data
);

   localparam int ITER_W = clog2_min1(MAX_ITER + 1);
   localparam int CNT_W  = clog2_min1(SETTLE_CYC);

   state_t                           state;
   logic [CH_W-1:0]                  ch;
   logic [CNT_W-1:0]                 cnt;
   logic [ITER_W-1:0]                iter;
   logic [ADC_W-1:0]                 v_lat;
   logic [NUM_CH-1:0][DRIVE_W-1:0]   drive_r;
   logic [NUM_CH-1:0][DCC_W-1:0]     dcc_r;
   logic [NUM_CH-1:0][GAIN_W-1:0]    gain_r;

   logic [DRIVE_W-1:0] n_drive;
   logic [DCC_W-1:0]   n_dcc;
   logic [GAIN_W-1:0]  n_gain;
   logic [ITER_W-1:0]  n_iter;
   logic               step_lock, step_fail;
   logic               cnt_last, last_ch, any_good, start_cal, show;
   logic [CH_W-1:0]    first_good, next_good;

   ppg_cal_step #(
      .ADC_W(ADC_W), .DRIVE_W(DRIVE_W), .DCC_W(DCC_W), .GAIN_W(GAIN_W),
      .ITER_W(ITER_W), .TARGET_LO(TARGET_LO), .TARGET_HI(TARGET_HI), .MAX_ITER(MAX_ITER)
   ) u_step (
      .v(v_lat), .drive(drive_r[ch]), .dcc(dcc_r[ch]), .gain(gain_r[ch]), .iter(iter),
      .next_drive(n_drive), .next_dcc(n_dcc), .next_gain(n_gain), .next_iter(n_iter),
      .lock(step_lock), .fail(step_fail)
   );

   assign cnt_last  = (cnt == CNT_W'(SETTLE_CYC - 1));
   assign last_ch   = (ch == CH_W'(NUM_CH - 1));
   assign any_good  = ~&cal_fail;
   assign start_cal = find_setting && ((state == ST_IDLE) || (state == ST_RUN_SETTLE));
   assign show      = (state == ST_CAL_SETTLE) || (state == ST_CAL_ADJUST) || (state == ST_RUN_SETTLE);
   assign busy      = (state != ST_IDLE);
   assign cal_done  = (state == ST_CAL_DONE);

   // Lowest good channel, and the next good channel above ch (wrapping to the lowest).
   always_comb begin
      first_good = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (!cal_fail[i]) first_good = CH_W'(i);
      next_good = first_good;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (!cal_fail[i] && (CH_W'(i) > ch)) next_good = CH_W'(i);
   end

   always_comb begin
      led_en    = '0;
      led_drive = '0;
      dc_comp   = '0;
      pga_gain  = '0;
      if (show) begin
         led_en[ch] = 1'b1;
         led_drive  = drive_r[ch];
         dc_comp    = dcc_r[ch];
         pga_gain   = gain_r[ch];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         ch           <= '0;
         cnt          <= '0;
         iter         <= '0;
         v_lat        <= '0;
         drive_r      <= '0;
         dcc_r        <= '0;
         gain_r       <= '0;
         cal_fail     <= '0;
         sample_valid <= 1'b0;
         sample_data  <= '0;
         sample_ch    <= '0;
      end else begin
         sample_valid <= 1'b0;
         sample_data  <= '0;
         sample_ch    <= '0;
         if (start_cal) begin
            // An in-progress RUN slot is simply dropped here.
            state      <= ST_CAL_SETTLE;
            ch         <= '0;
            cnt        <= '0;
            iter       <= '0;
            cal_fail   <= '0;
            drive_r[0] <= DRIVE_W'(DRIVE_INIT);
            dcc_r[0]   <= '0;
            gain_r[0]  <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (run_en && any_good) begin
                     state <= ST_RUN_SETTLE;
                     ch    <= first_good;
                     cnt   <= '0;
                  end
               end
               ST_CAL_SETTLE: begin
                  if (cnt_last) begin
                     v_lat <= adc;
                     cnt   <= '0;
                     state <= ST_CAL_ADJUST;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               ST_CAL_ADJUST: begin
                  drive_r[ch] <= n_drive;
                  dcc_r[ch]   <= n_dcc;
                  gain_r[ch]  <= n_gain;
                  iter        <= n_iter;
                  state       <= ST_CAL_SETTLE;
                  if (step_lock || step_fail) begin
                     cal_fail[ch] <= step_fail;
                     if (last_ch) begin
                        state <= ST_CAL_DONE;
                     end else begin
                        ch                  <= ch + 1'b1;
                        iter                <= '0;
                        drive_r[ch + 1'b1]  <= DRIVE_W'(DRIVE_INIT);
                        dcc_r[ch + 1'b1]    <= '0;
                        gain_r[ch + 1'b1]   <= '0;
                     end
                  end
               end
               ST_CAL_DONE: begin
                  if (run_en && any_good) begin
                     state <= ST_RUN_SETTLE;
                     ch    <= first_good;
                     cnt   <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
               ST_RUN_SETTLE: begin
                  if (!run_en) begin
                     state <= ST_IDLE;
                  end else if (cnt_last) begin
                     sample_valid <= 1'b1;
                     sample_data  <= adc;
                     sample_ch    <= ch;
                     ch           <= next_good;
                     cnt          <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ppg_multichannel_calibrator.sv
// Bench: a parametric optical plant closes the loop around the calibrator; table and
// random plants are checked against hand-derived values and a search model.
module tb_ppg_multichannel_calibrator;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       find_setting, run_en;
   logic [7:0] adc;
   logic [1:0] led_en, cal_fail;
   logic [3:0] led_drive, pga_gain;
   logic [6:0] dc_comp;
   logic       busy, cal_done, sample_valid;
   logic [0:0] sample_ch;
   logic [7:0] sample_data;

   logic       find3, run3;
   logic [7:0] adc3;
   logic [2:0] led_en3, cal_fail3;
   logic [3:0] led_drive3, pga_gain3;
   logic [6:0] dc_comp3;
   logic       busy3, cal_done3, sv3;
   logic [1:0] sch3;
   logic [7:0] sd3;

   ppg_multichannel_calibrator dut (
      .clk(clk), .rst_n(rst_n), .find_setting(find_setting), .run_en(run_en), .adc(adc),
      .led_en(led_en), .led_drive(led_drive), .dc_comp(dc_comp), .pga_gain(pga_gain),
      .busy(busy), .cal_done(cal_done), .cal_fail(cal_fail), .sample_valid(sample_valid),
      .sample_ch(sample_ch), .sample_data(sample_data));

   ppg_multichannel_calibrator #(.NUM_CH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .find_setting(find3), .run_en(run3), .adc(adc3),
      .led_en(led_en3), .led_drive(led_drive3), .dc_comp(dc_comp3), .pga_gain(pga_gain3),
      .busy(busy3), .cal_done(cal_done3), .cal_fail(cal_fail3), .sample_valid(sv3),
      .sample_ch(sch3), .sample_data(sd3));

   assign adc3 = 8'd128;

   // Plant: adc = clamp(base + gk*gain - dk*dcc + rk*(drive-8)) for the lit channel.
   int pb[2], pg[2], pd[2], pr[2];
   int adc_c, adc_v;
   always_comb begin
      adc_c = led_en[1] ? 1 : 0;
      adc_v = pb[adc_c] + pg[adc_c] * int'(pga_gain) - pd[adc_c] * int'(dc_comp)
              + pr[adc_c] * (int'(led_drive) - 8);
      if (adc_v < 0)   adc_v = 0;
      if (adc_v > 255) adc_v = 255;
      adc = 8'(adc_v);
   end

   function automatic int plant(input int c, input int d, input int dc, input int g);
      int v;
      v = pb[c] + pg[c] * g - pd[c] * dc + pr[c] * (d - 8);
      return (v < 0) ? 0 : (v > 255) ? 255 : v;
   endfunction

   // Reference search: iterate the adjustment rules on the plant until lock/fail/limit.
   function automatic void cal_model(input int c, output int it, output int f,
                                     output int d, output int dc, output int g);
      int v;
      d = 8; dc = 0; g = 0; f = 0; it = 0;
      for (int k = 0; k < 64; k++) begin
         v = plant(c, d, dc, g);
         it++;
         if (v >= 64 && v <= 192) return;
         if (v > 192) begin
            if (dc < 127) dc++; else if (d > 0) d--; else begin f = 1; return; end
         end else begin
            if (g < 15) g++; else if (d < 15) d++; else begin f = 1; return; end
         end
      end
      f = 1;
   endfunction

   typedef struct {
      int b0, b1, g0, g1, d0, d1, r0, r1;
      int cyc, fl;
      int ed0, edc0, eg0, ed1, edc1, eg1;
   } vec_t;

   vec_t  tbl[7];
   int    tests = 0, fails = 0;
   int    ed[2], edc[2], eg[2], efl, ecyc;
   string vname;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s/%s: got %0d, expected %0d", vname, name, act, exp);
      end
   endtask

   task automatic load_vec(input vec_t v);
      pb[0] = v.b0; pb[1] = v.b1; pg[0] = v.g0; pg[1] = v.g1;
      pd[0] = v.d0; pd[1] = v.d1; pr[0] = v.r0; pr[1] = v.r1;
      ecyc = v.cyc; efl = v.fl;
      ed[0] = v.ed0; edc[0] = v.edc0; eg[0] = v.eg0;
      ed[1] = v.ed1; edc[1] = v.edc1; eg[1] = v.eg1;
   endtask

   task automatic run_vec();
      int n, last, found, nk, c, nx;
      int good[2];
      run_en = 1'b0; find_setting = 1'b0;
      repeat (3) @(posedge clk);
      #1 run_en = 1'b1; find_setting = 1'b1;
      @(posedge clk); #1 find_setting = 1'b0;
      chk("busy at start", int'(busy), 1);
      n = 1;
      while (!cal_done && n < 1000) begin @(posedge clk); #1 n++; end
      chk("cal_done cycle", n, ecyc);
      chk("cal_fail", int'(cal_fail), efl);
      nk = 0;
      for (int i = 0; i < 2; i++) if (((efl >> i) & 1) == 0) begin good[nk] = i; nk++; end
      found = 0;
      if (nk == 0) begin
         @(posedge clk); #1 chk("idle after all fail", int'(busy), 0);
         repeat (10) begin @(posedge clk); #1 if (sample_valid) found++; end
         chk("no samples", found, 0);
      end else begin
         last = 0;
         for (int k = 1; k <= 40 && found < 5; k++) begin
            @(posedge clk); #1;
            if (sample_valid) begin
               c  = good[found % nk];
               nx = good[(found + 1) % nk];
               chk("sample gap", k - last, (found == 0) ? 5 : 4);
               chk("sample_ch", int'(sample_ch), c);
               chk("sample_data", int'(sample_data), plant(c, ed[c], edc[c], eg[c]));
               chk("led_en slot", int'(led_en), 1 << nx);
               chk("slot codes", int'({led_drive, dc_comp, pga_gain}),
                   (ed[nx] << 11) | (edc[nx] << 4) | eg[nx]);
               last = k;
               found++;
            end
         end
         chk("sample count", found, 5);
      end
   endtask

   initial begin
      int n, bad, k, it0, it1, f0, f1;
      vec_t rv;
      find_setting = 1'b0; run_en = 1'b0; find3 = 1'b0; run3 = 1'b0;
      for (int i = 0; i < 2; i++) begin pb[i] = 0; pg[i] = 0; pd[i] = 0; pr[i] = 0; end
      //           b0  b1  g0 g1 d0 d1 r0 r1 cyc fl  ed0 edc0 eg0 ed1 edc1 eg1
      tbl[0] = '{128, 128, 0, 0, 0, 0, 0, 0, 11, 0, 8, 0, 0, 8, 0, 0};
      tbl[1] = '{230, 230, 0, 0, 10, 10, 0, 0, 51, 0, 8, 4, 0, 8, 4, 0};
      tbl[2] = '{128, 0, 0, 0, 0, 0, 0, 0, 121, 2, 8, 0, 0, 0, 0, 0};
      tbl[3] = '{255, 256, 0, 0, 1, 1, 0, 0, 641, 2, 8, 63, 0, 0, 0, 0};
      tbl[4] = '{40, 20, 5, 2, 0, 0, 0, 3, 136, 0, 8, 0, 5, 13, 0, 15};
      tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 231, 3, 0, 0, 0, 0, 0, 0};
      tbl[6] = '{0, 128, 0, 0, 0, 0, 0, 0, 121, 1, 0, 0, 0, 8, 0, 0};

      vname = "reset";
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("led_en", int'(led_en), 0);
      chk("codes", int'({led_drive, dc_comp, pga_gain}), 0);
      chk("busy", int'(busy), 0);
      chk("cal_done", int'(cal_done), 0);
      chk("cal_fail", int'(cal_fail), 0);
      chk("sample", int'({sample_valid, sample_ch, sample_data}), 0);
      chk("dut3 busy", int'(busy3), 0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         $sformat(vname, "vec%0d", i);
         load_vec(tbl[i]);
         run_vec();
      end

      // find_setting mid-slot (after vec6, RUN on ch1 only): restart, no sample for that slot.
      vname = "abort_find";
      k = 0;
      while (!sample_valid && k < 20) begin @(posedge clk); #1 k++; end
      chk("pre sample", int'(sample_valid), 1);
      @(posedge clk); #1 find_setting = 1'b1;
      @(posedge clk); #1 find_setting = 1'b0;
      chk("cal_fail cleared", int'(cal_fail), 0);
      n = 1; bad = 0;
      while (!cal_done && n < 1000) begin
         if (sample_valid || !busy) bad++;
         @(posedge clk); #1 n++;
      end
      chk("cal_done cycle", n, 121);
      chk("no sample or idle during restart", bad, 0);

      // run_en drop mid-slot: straight to IDLE, slot discarded.
      vname = "abort_run";
      k = 0;
      while (!sample_valid && k < 20) begin @(posedge clk); #1 k++; end
      chk("pre sample", int'(sample_valid), 1);
      @(posedge clk); #1 run_en = 1'b0;
      @(posedge clk); #1;
      chk("busy", int'(busy), 0);
      chk("led_en", int'(led_en), 0);
      bad = 0;
      repeat (6) begin @(posedge clk); #1 if (sample_valid) bad++; end
      chk("no sample", bad, 0);

      for (int t = 0; t < 8; t++) begin
         $sformat(vname, "rand%0d", t);
         rv.b0 = int'($urandom_range(0, 300)); rv.b1 = int'($urandom_range(0, 300));
         rv.g0 = int'($urandom_range(0, 6));   rv.g1 = int'($urandom_range(0, 6));
         rv.d0 = int'($urandom_range(0, 12));  rv.d1 = int'($urandom_range(0, 12));
         rv.r0 = int'($urandom_range(0, 8));   rv.r1 = int'($urandom_range(0, 8));
         load_vec(rv);
         cal_model(0, it0, f0, ed[0], edc[0], eg[0]);
         cal_model(1, it1, f1, ed[1], edc[1], eg[1]);
         ecyc = (it0 + it1) * 5 + 1;
         efl  = f0 | (f1 << 1);
         run_vec();
      end

      // Asynchronous reset in RUN with a failed channel flagged.
      vname = "reset_mid_run";
      load_vec(tbl[6]);
      run_vec();
      @(posedge clk); #3 rst_n = 1'b0; run_en = 1'b0;
      #1;
      chk("led_en", int'(led_en), 0);
      chk("codes", int'({led_drive, dc_comp, pga_gain}), 0);
      chk("busy", int'(busy), 0);
      chk("cal_fail", int'(cal_fail), 0);
      chk("sample", int'({sample_valid, sample_ch, sample_data}), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("busy after release", int'(busy), 0);

      // Three-channel round robin.
      vname = "rr3";
      #1 find3 = 1'b1; run3 = 1'b1;
      @(posedge clk); #1 find3 = 1'b0;
      n = 1;
      while (!cal_done3 && n < 1000) begin @(posedge clk); #1 n++; end
      chk("cal_done cycle", n, 16);
      chk("cal_fail", int'(cal_fail3), 0);
      k = 0; bad = 0;
      for (int j = 1; j <= 40 && k < 6; j++) begin
         @(posedge clk); #1;
         if (sv3) begin
            chk("sample gap", j - bad, (k == 0) ? 5 : 4);
            chk("sample_ch", int'(sch3), k % 3);
            chk("sample_data", int'(sd3), 128);
            chk("led_en slot", int'(led_en3), 1 << ((k + 1) % 3));
            chk("slot codes", int'({led_drive3, dc_comp3, pga_gain3}), 8 << 11);
            bad = j;
            k++;
         end
      end
      chk("sample count", k, 6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
